wb_arbiter: RTL and testbench

Writeback arbiter sitting between the execution units and the register file write ports. Per lane (A, B) it merges the arithmetic result stream and the load/store result stream onto a single register-file write port. Arithmetic results are buffered in a per-lane FIFO with valid/ready backpressure. Load/store results take priority, subject to an anti-starvation counter.

---
 rtl/wb_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-lane writeback arbiter: load/store results win over buffered arithmetic results,
// with an anti-starvation throttle. Define WB_FWD_EN to build the FIFO forwarding lookup.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        wbA_arith_i,
    input  logic [4:0]  wbAddrA_arith_i,
    input  logic [15:0] wbValA_arith_i,
    input  logic [1:0]  operationStatusA_i,
    output logic        arithReadyA_o,
    input  logic        wbA_ls_i,
    input  logic [4:0]  wbAddrA_ls_i,
    input  logic [15:0] wbValA_ls_i,
    output logic        lsReadyA_o,
    output logic        wbA_o,
    output logic [4:0]  wbAddrA_o,
    output logic [15:0] wbDatA_o,
    output logic        statusWeA_o,
    output logic [1:0]  operationStatusA_o,
    input  logic [4:0]  fwdAddrA_i,
    output logic        fwdHitA_o,
    output logic [15:0] fwdDatA_o,
    input  logic        wbB_arith_i,
    input  logic [4:0]  wbAddrB_arith_i,
    input  logic [15:0] wbValB_arith_i,
    input  logic [1:0]  operationStatusB_i,
    output logic        arithReadyB_o,
    input  logic        wbB_ls_i,
    input  logic [4:0]  wbAddrB_ls_i,
    input  logic [15:0] wbValB_ls_i,
    output logic        lsReadyB_o,
    output logic        wbB_o,
    output logic [4:0]  wbAddrB_o,
    output logic [15:0] wbDatB_o,
    output logic        statusWeB_o,
    output logic [1:0]  operationStatusB_o,
    input  logic [4:0]  fwdAddrB_i,
    output logic        fwdHitB_o,
    output logic [15:0] fwdDatB_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned EW = 23;

    logic        ar_v    [2];
    logic [4:0]  ar_addr [2];
    logic [15:0] ar_val  [2];
    logic [1:0]  ar_st   [2];
    logic        ls_v    [2];
    logic [4:0]  ls_addr [2];
    logic [15:0] ls_val  [2];
    logic        ar_rdy  [2];
    logic        ls_rdy  [2];
    logic        wb      [2];
    logic [4:0]  wb_addr [2];
    logic [15:0] wb_dat  [2];
    logic        st_we   [2];
    logic [1:0]  st      [2];
    logic        fwd_hit [2];
    logic [15:0] fwd_dat [2];

    assign ar_v[0]    = wbA_arith_i;
    assign ar_addr[0] = wbAddrA_arith_i;
    assign ar_val[0]  = wbValA_arith_i;
    assign ar_st[0]   = operationStatusA_i;
    assign ls_v[0]    = wbA_ls_i;
    assign ls_addr[0] = wbAddrA_ls_i;
    assign ls_val[0]  = wbValA_ls_i;
    assign ar_v[1]    = wbB_arith_i;
    assign ar_addr[1] = wbAddrB_arith_i;
    assign ar_val[1]  = wbValB_arith_i;
    assign ar_st[1]   = operationStatusB_i;
    assign ls_v[1]    = wbB_ls_i;
    assign ls_addr[1] = wbAddrB_ls_i;
    assign ls_val[1]  = wbValB_ls_i;

`ifdef WB_FWD_EN
    logic [4:0] fwd_addr [2];
    assign fwd_addr[0] = fwdAddrA_i;
    assign fwd_addr[1] = fwdAddrB_i;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwdAddrA_i, fwdAddrB_i};
`endif

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [EW-1:0] mem_q [DEPTH];
        logic [PW-1:0] rd_ptr_q, wr_ptr_q;
        logic [CW-1:0] count_q, count_d;
        logic [SW-1:0] starve_q, starve_d;
        logic          ar_rdy_q, ls_rdy_q, wb_q, st_we_q;
        logic [4:0]    addr_q;
        logic [15:0]   dat_q;
        logic [1:0]    st_q;
        logic          ls_win, push_in, fifo_ne, push, pop;
        logic [EW-1:0] head, in_ent;

        always_comb begin
            ls_win   = ls_v[l] & ls_rdy_q;
            push_in  = ar_v[l] & ar_rdy_q;
            fifo_ne  = (count_q != '0);
            pop      = fifo_ne & ~ls_win;
            // Write-through only when nothing is queued; otherwise order demands a push.
            push     = push_in & (ls_win | fifo_ne);
            head     = mem_q[rd_ptr_q];
            in_ent   = {ar_addr[l], ar_val[l], ar_st[l]};
            count_d  = count_q;
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            starve_d = (ls_win && fifo_ne) ? starve_q + SW'(1) : '0;
        end

        always_ff @(posedge clock_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_ent;
            end
        end

        always_ff @(posedge clock_i or negedge reset_i) begin
            if (!reset_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                starve_q <= '0;
                ar_rdy_q <= 1'b1;
                ls_rdy_q <= 1'b1;
                wb_q     <= 1'b0;
                st_we_q  <= 1'b0;
                addr_q   <= '0;
                dat_q    <= '0;
                st_q     <= '0;
            end else begin
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                count_q  <= count_d;
                starve_q <= starve_d;
                ar_rdy_q <= (count_d < CW'(DEPTH));
                ls_rdy_q <= (starve_d != SW'(STARVE_LIMIT));
                wb_q     <= ls_win | fifo_ne | push_in;
                st_we_q  <= ~ls_win & (fifo_ne | push_in);
                if (ls_win) begin
                    addr_q <= ls_addr[l];
                    dat_q  <= ls_val[l];
                end else if (fifo_ne) begin
                    {addr_q, dat_q, st_q} <= head;
                end else if (push_in) begin
                    {addr_q, dat_q, st_q} <= in_ent;
                end
            end
        end

        assign ar_rdy[l]  = ar_rdy_q;
        assign ls_rdy[l]  = ls_rdy_q;
        assign wb[l]      = wb_q;
        assign wb_addr[l] = addr_q;
        assign wb_dat[l]  = dat_q;
        assign st_we[l]   = st_we_q;
        assign st[l]      = st_q;

`ifdef WB_FWD_EN
        logic        hit_c;
        logic [15:0] fdat_c;

        // Walk head to tail so the youngest matching entry overwrites older ones.
        always_comb begin
            hit_c  = 1'b0;
            fdat_c = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (mem_q[rd_ptr_q + PW'(i)][22:18] == fwd_addr[l])) begin
                    hit_c  = 1'b1;
                    fdat_c = mem_q[rd_ptr_q + PW'(i)][17:2];
                end
            end
        end

        assign fwd_hit[l] = hit_c;
        assign fwd_dat[l] = fdat_c;
`else
        assign fwd_hit[l] = 1'b0;
        assign fwd_dat[l] = '0;
`endif
    end

    assign arithReadyA_o      = ar_rdy[0];
    assign lsReadyA_o         = ls_rdy[0];
    assign wbA_o              = wb[0];
    assign wbAddrA_o          = wb_addr[0];
    assign wbDatA_o           = wb_dat[0];
    assign statusWeA_o        = st_we[0];
    assign operationStatusA_o = st[0];
    assign fwdHitA_o          = fwd_hit[0];
    assign fwdDatA_o          = fwd_dat[0];
    assign arithReadyB_o      = ar_rdy[1];
    assign lsReadyB_o         = ls_rdy[1];
    assign wbB_o              = wb[1];
    assign wbAddrB_o          = wb_addr[1];
    assign wbDatB_o           = wb_dat[1];
    assign statusWeB_o        = st_we[1];
    assign operationStatusB_o = st[1];
    assign fwdHitB_o          = fwd_hit[1];
    assign fwdDatB_o          = fwd_dat[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: queue-based lane model checked every cycle, plus directed
// scenarios with literal expectations (write-through, LS priority, starvation, wrap, reset).
module tb_wb_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
        logic [1:0]  s;
    } ent_t;

    logic clk;
    logic rst_n;

    logic        ar_v     [2];
    logic [4:0]  ar_addr  [2];
    logic [15:0] ar_dat   [2];
    logic [1:0]  ar_st    [2];
    logic        ls_v     [2];
    logic [4:0]  ls_addr  [2];
    logic [15:0] ls_dat   [2];
    logic [4:0]  fwd_addr [2];

    logic        ar_rdy_o [2];
    logic        ls_rdy_o [2];
    logic        wb_o     [2];
    logic [4:0]  addr_o   [2];
    logic [15:0] dat_o    [2];
    logic        st_we_o  [2];
    logic [1:0]  st_o     [2];
    logic        hit_o    [2];
    logic [15:0] fdat_o   [2];

    int checks   = 0;
    int failures = 0;

    // Model state
    ent_t        q [2][$];
    int          m_starve [2] = '{0, 0};
    bit          m_lsrdy  [2] = '{1, 1};
    bit          m_arrdy  [2] = '{1, 1};
    bit          e_wb     [2] = '{0, 0};
    logic [4:0]  e_addr   [2] = '{0, 0};
    logic [15:0] e_dat    [2] = '{0, 0};
    bit          e_we     [2] = '{0, 0};
    logic [1:0]  e_st     [2] = '{0, 0};

    bit          ar_taken [2];
    bit          ls_taken [2];
    bit          collect_b = 0;
    logic [15:0] got_b [$];

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock_i            (clk),
        .reset_i            (rst_n),
        .wbA_arith_i        (ar_v[0]),
        .wbAddrA_arith_i    (ar_addr[0]),
        .wbValA_arith_i     (ar_dat[0]),
        .operationStatusA_i (ar_st[0]),
        .arithReadyA_o      (ar_rdy_o[0]),
        .wbA_ls_i           (ls_v[0]),
        .wbAddrA_ls_i       (ls_addr[0]),
        .wbValA_ls_i        (ls_dat[0]),
        .lsReadyA_o         (ls_rdy_o[0]),
        .wbA_o              (wb_o[0]),
        .wbAddrA_o          (addr_o[0]),
        .wbDatA_o           (dat_o[0]),
        .statusWeA_o        (st_we_o[0]),
        .operationStatusA_o (st_o[0]),
        .fwdAddrA_i         (fwd_addr[0]),
        .fwdHitA_o          (hit_o[0]),
        .fwdDatA_o          (fdat_o[0]),
        .wbB_arith_i        (ar_v[1]),
        .wbAddrB_arith_i    (ar_addr[1]),
        .wbValB_arith_i     (ar_dat[1]),
        .operationStatusB_i (ar_st[1]),
        .arithReadyB_o      (ar_rdy_o[1]),
        .wbB_ls_i           (ls_v[1]),
        .wbAddrB_ls_i       (ls_addr[1]),
        .wbValB_ls_i        (ls_dat[1]),
        .lsReadyB_o         (ls_rdy_o[1]),
        .wbB_o              (wb_o[1]),
        .wbAddrB_o          (addr_o[1]),
        .wbDatB_o           (dat_o[1]),
        .statusWeB_o        (st_we_o[1]),
        .operationStatusB_o (st_o[1]),
        .fwdAddrB_i         (fwd_addr[1]),
        .fwdHitB_o          (hit_o[1]),
        .fwdDatB_o          (fdat_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: priority LS > queued > write-through, per lane, applied at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                q[l].delete();
                m_starve[l] = 0;
                m_lsrdy[l]  = 1;
                m_arrdy[l]  = 1;
                e_wb[l]     = 0;
                e_addr[l]   = '0;
                e_dat[l]    = '0;
                e_we[l]     = 0;
                e_st[l]     = '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                bit   lsw;
                bit   pin;
                bit   ne;
                ent_t h;
                lsw     = ls_v[l] && m_lsrdy[l];
                pin     = ar_v[l] && m_arrdy[l];
                ne      = (q[l].size() != 0);
                e_wb[l] = 0;
                e_we[l] = 0;
                if (lsw) begin
                    e_wb[l]   = 1;
                    e_addr[l] = ls_addr[l];
                    e_dat[l]  = ls_dat[l];
                end else if (ne) begin
                    h         = q[l].pop_front();
                    e_wb[l]   = 1;
                    e_we[l]   = 1;
                    e_addr[l] = h.a;
                    e_dat[l]  = h.d;
                    e_st[l]   = h.s;
                end else if (pin) begin
                    e_wb[l]   = 1;
                    e_we[l]   = 1;
                    e_addr[l] = ar_addr[l];
                    e_dat[l]  = ar_dat[l];
                    e_st[l]   = ar_st[l];
                end
                if (pin && (lsw || ne)) q[l].push_back('{a: ar_addr[l], d: ar_dat[l], s: ar_st[l]});
                m_starve[l] = (lsw && ne) ? m_starve[l] + 1 : 0;
                m_lsrdy[l]  = (m_starve[l] != STARVE_LIMIT);
                m_arrdy[l]  = (q[l].size() < DEPTH);
            end
            #1;
            for (int l = 0; l < 2; l++) begin
                bit          e_hit;
                logic [15:0] e_fd;
                e_hit = 0;
                e_fd  = '0;
`ifdef WB_FWD_EN
                foreach (q[l][i]) begin
                    if (q[l][i].a == fwd_addr[l]) begin
                        e_hit = 1;
                        e_fd  = q[l][i].d;
                    end
                end
`endif
                chk($sformatf("lane%0d_wb", l), wb_o[l], e_wb[l]);
                chk($sformatf("lane%0d_addr", l), addr_o[l], e_addr[l]);
                chk($sformatf("lane%0d_dat", l), dat_o[l], e_dat[l]);
                chk($sformatf("lane%0d_statuswe", l), st_we_o[l], e_we[l]);
                chk($sformatf("lane%0d_status", l), st_o[l], e_st[l]);
                chk($sformatf("lane%0d_arithready", l), ar_rdy_o[l], m_arrdy[l]);
                chk($sformatf("lane%0d_lsready", l), ls_rdy_o[l], m_lsrdy[l]);
                chk($sformatf("lane%0d_fwdhit", l), hit_o[l], e_hit);
                chk($sformatf("lane%0d_fwddat", l), fdat_o[l], e_fd);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (collect_b && wb_o[1] && st_we_o[1]) got_b.push_back(dat_o[1]);
    end

    // One clock from negedge to negedge, recording which handshakes completed.
    task automatic tick();
        bit acc_ar [2];
        bit acc_ls [2];
        for (int l = 0; l < 2; l++) begin
            acc_ar[l] = ar_v[l] && ar_rdy_o[l];
            acc_ls[l] = ls_v[l] && ls_rdy_o[l];
        end
        @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            ar_taken[l] = acc_ar[l];
            ls_taken[l] = acc_ls[l];
        end
    endtask

    task automatic idle_inputs();
        for (int l = 0; l < 2; l++) begin
            ar_v[l] = 1'b0;
            ls_v[l] = 1'b0;
        end
    endtask

    initial begin
        int n;
        int k;
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            ar_v[l] = 0; ar_addr[l] = '0; ar_dat[l] = '0; ar_st[l] = '0;
            ls_v[l] = 0; ls_addr[l] = '0; ls_dat[l] = '0;
        end
        fwd_addr[0] = 5'd7;
        fwd_addr[1] = 5'd9;
        repeat (2) @(negedge clk);
        chk("reset_wb", wb_o[0], 0);
        chk("reset_arithready", ar_rdy_o[0], 1);
        chk("reset_lsready", ls_rdy_o[1], 1);
        chk("reset_fwdhit", hit_o[0], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Single write-through
        ar_v[0] = 1; ar_addr[0] = 5'd3; ar_dat[0] = 16'h1234; ar_st[0] = 2'b01;
        tick();
        chk("wt_wb", wb_o[0], 1);
        chk("wt_addr", addr_o[0], 3);
        chk("wt_dat", dat_o[0], 16'h1234);
        chk("wt_statuswe", st_we_o[0], 1);
        chk("wt_status", st_o[0], 2'b01);
        ar_v[0] = 0;
        tick();
        chk("idle_wb", wb_o[0], 0);
        chk("idle_dat_hold", dat_o[0], 16'h1234);

        // LS and arithmetic collide: LS first, arithmetic from FIFO next
        ls_v[0] = 1; ls_addr[0] = 5'd5; ls_dat[0] = 16'hBEEF;
        ar_v[0] = 1; ar_addr[0] = 5'd6; ar_dat[0] = 16'h0001; ar_st[0] = 2'b10;
        tick();
        chk("ls_first_addr", addr_o[0], 5);
        chk("ls_first_dat", dat_o[0], 16'hBEEF);
        chk("ls_first_statuswe", st_we_o[0], 0);
        chk("ls_first_status_hold", st_o[0], 2'b01);
        idle_inputs();
        tick();
        chk("fifo_next_addr", addr_o[0], 6);
        chk("fifo_next_dat", dat_o[0], 16'h0001);
        chk("fifo_next_statuswe", st_we_o[0], 1);
        chk("fifo_next_status", st_o[0], 2'b10);
        tick();

        // Continuous LS with DEPTH+1 arithmetic pushes: backpressure and starvation throttle
        n = 0; k = 0;
        ls_v[0] = 1; ls_addr[0] = 5'd2; ls_dat[0] = 16'hC000;
        ar_v[0] = 1; ar_addr[0] = 5'd10; ar_dat[0] = 16'h3000; ar_st[0] = 2'b11;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            if (ar_taken[0]) begin
                n++;
                if (n == DEPTH + 1) ar_v[0] = 0;
                else begin
                    ar_addr[0] = 5'(10 + n);
                    ar_dat[0]  = 16'(16'h3000 + n);
                end
            end
            if (ls_taken[0]) begin
                k++;
                ls_dat[0] = 16'(16'hC000 + k);
            end
            if (cyc == 3) chk("starve_arithready_c3", ar_rdy_o[0], 1);
            if (cyc == 4) chk("starve_arithready_c4", ar_rdy_o[0], 0);
            if (cyc == 8) chk("starve_lsready_c8", ls_rdy_o[0], 1);
            if (cyc == 9) chk("starve_lsready_c9", ls_rdy_o[0], 0);
            if (cyc == 10) begin
                chk("starve_head_wb", wb_o[0], 1);
                chk("starve_head_dat", dat_o[0], 16'h3000);
                chk("starve_head_statuswe", st_we_o[0], 1);
                chk("starve_lsready_c10", ls_rdy_o[0], 1);
            end
        end
        idle_inputs();
        repeat (8) tick();

        // FIFO wrap on lane B: 10 arithmetic values against alternating LS traffic
        n = 0; k = 0;
        collect_b = 1;
        ar_v[1] = 1; ar_addr[1] = 5'd20; ar_dat[1] = 16'h4000; ar_st[1] = 2'b01;
        ls_v[1] = 1; ls_addr[1] = 5'd9; ls_dat[1] = 16'hA000;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (ar_taken[1]) begin
                n++;
                if (n == 10) ar_v[1] = 0;
                else begin
                    ar_addr[1] = 5'(20 + (n % 4));
                    ar_dat[1]  = 16'(16'h4000 + n);
                end
            end
            if (ls_taken[1]) ls_v[1] = 0;
            else if (!ls_v[1] && n < 10) begin
                k++;
                ls_v[1]   = 1;
                ls_dat[1] = 16'(16'hA000 + k);
            end
        end
        idle_inputs();
        repeat (8) tick();
        collect_b = 0;
        chk("wrap_count", got_b.size(), 10);
        for (int i = 0; i < got_b.size() && i < 10; i++) begin
            chk($sformatf("wrap_order%0d", i), got_b[i], 16'(16'h4000 + i));
        end

        // Forwarding lookup with two pending r7 entries
        ls_v[0] = 1; ls_addr[0] = 5'd1; ls_dat[0] = 16'h5555;
        ar_v[0] = 1; ar_addr[0] = 5'd7; ar_dat[0] = 16'h0011; ar_st[0] = 2'b00;
        tick();
        ar_dat[0] = 16'h0022;
        tick();
        ar_v[0] = 0;
        #1;
`ifdef WB_FWD_EN
        chk("fwd_hit", hit_o[0], 1);
        chk("fwd_dat", fdat_o[0], 16'h0022);
`else
        chk("fwd_hit_disabled", hit_o[0], 0);
        chk("fwd_dat_disabled", fdat_o[0], 0);
`endif
        ls_v[0] = 0;
        repeat (4) tick();

        // Reset with three entries pending
        ls_v[0] = 1; ls_addr[0] = 5'd4; ls_dat[0] = 16'h7777;
        ar_v[0] = 1; ar_addr[0] = 5'd8; ar_st[0] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            ar_dat[0] = 16'(16'h6000 + i);
            tick();
        end
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_wb", wb_o[0], 0);
        chk("midreset_addr", addr_o[0], 0);
        chk("midreset_dat", dat_o[0], 0);
        chk("midreset_arithready", ar_rdy_o[0], 1);
        chk("midreset_lsready", ls_rdy_o[0], 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        repeat (6) tick();
        chk("post_reset_no_stale_wb", wb_o[0], 0);
        chk("post_reset_dat", dat_o[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
